// File: rtl/bus_router.sv
// -----------------------------------------------------------------------------
// bus_router
//
// Single-master address router. A request presented on the req_* handshake is
// decoded against NUM_REGIONS address windows. On a hit the region-relative
// offset, write flag and write data are forwarded on a shared slave bus while
// the matching slv_valid strobe is held until that port answers with slv_ready.
// On a miss an error response is returned without touching any slave. Exactly
// one transaction is in flight at a time; every transaction, hit or miss,
// ends with a single-cycle resp_valid pulse.
//
// Optional feature (macro BUS_ROUTER_TIMEOUT_EN):
//   When defined, an ACCESS phase that sees no slv_ready for TIMEOUT_CYCLES
//   cycles is abandoned and answered with an error response. When undefined,
//   ACCESS waits indefinitely and no timeout counter is built.
//
// Parameters
//   NUM_REGIONS    number of target regions / slave ports (1..8)
//   DATA_W         data width (address width is fixed at 32)
//   REGION_BASE    packed NUM_REGIONS x 32 base addresses, entry 0 in the LSBs
//   REGION_SIZE    packed NUM_REGIONS x 32 sizes in bytes, each nonzero
//   TIMEOUT_CYCLES ACCESS cycles without slv_ready before an error response
//
// Ports
//   clk, rst                    rising-edge clock, asynchronous active-high reset
//   req_valid / req_ready       master request handshake
//   req_addr/req_we/req_wdata   request address, write flag, write data
//   slv_valid / slv_ready       per-port strobe (one-hot or zero) / per-port ready
//   slv_addr/slv_we/slv_wdata   shared slave bus, slv_addr is the region offset
//   slv_rdata                   packed per-port read data, port 0 in the LSBs
//   resp_valid                  one-cycle response pulse
//   resp_rdata/resp_err/resp_sel response data, error flag, region index
//                               (held until the next response)
// -----------------------------------------------------------------------------
module bus_router #(
    parameter int                        NUM_REGIONS    = 4,
    parameter int                        DATA_W         = 32,
    parameter logic [NUM_REGIONS*32-1:0] REGION_BASE    = {32'h1000_2000, 32'h1000_0000,
                                                           32'h8000_2000, 32'h8000_0000},
    parameter logic [NUM_REGIONS*32-1:0] REGION_SIZE    = {32'h0000_0010, 32'h0000_0010,
                                                           32'h0000_8000, 32'h0000_2000},
    parameter int                        TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [31:0]                   req_addr,
    input  logic                          req_we,
    input  logic [DATA_W-1:0]             req_wdata,

    output logic [NUM_REGIONS-1:0]        slv_valid,
    input  logic [NUM_REGIONS-1:0]        slv_ready,
    output logic [31:0]                   slv_addr,
    output logic                          slv_we,
    output logic [DATA_W-1:0]             slv_wdata,
    input  logic [NUM_REGIONS*DATA_W-1:0] slv_rdata,

    output logic                          resp_valid,
    output logic [DATA_W-1:0]             resp_rdata,
    output logic                          resp_err,
    output logic [2:0]                    resp_sel
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Elaboration-time parameter sanity checks
    // -------------------------------------------------------------------------
    if (NUM_REGIONS < 1 || NUM_REGIONS > 8) begin : g_bad_num_regions
        $error("bus_router: NUM_REGIONS must be in 1..8");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("bus_router: TIMEOUT_CYCLES must be at least 1");
    end

    // -------------------------------------------------------------------------
    // Address decode
    // -------------------------------------------------------------------------
    logic [NUM_REGIONS-1:0] w_in_region;
    logic                   w_hit;
    logic [2:0]             w_hit_idx;
    logic [31:0]            w_hit_base;
    logic [31:0]            w_hit_offset;
    logic [NUM_REGIONS-1:0] w_hit_onehot;

    for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_region
        // Bounds are widened to 33 bits so a region ending exactly at 2^32
        // produces an upper bound of 0x1_0000_0000 instead of wrapping to 0.
        localparam logic [32:0] LO = {1'b0, REGION_BASE[g*32 +: 32]};
        localparam logic [32:0] HI = LO + {1'b0, REGION_SIZE[g*32 +: 32]};

        if (REGION_SIZE[g*32 +: 32] == 32'h0) begin : g_bad_size
            $error("bus_router: REGION_SIZE entries must be nonzero");
        end

        assign w_in_region[g] = ({1'b0, req_addr} >= LO) && ({1'b0, req_addr} < HI);
    end

    // Scanning from the top index down lets the lowest matching index win.
    always_comb begin
        // NOTE: every signal gets a default before any conditional assignment,
        // otherwise paths that skip an assignment would infer a latch.
        w_hit        = 1'b0;
        w_hit_idx    = 3'd0;
        w_hit_base   = 32'h0;
        w_hit_onehot = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (w_in_region[i]) begin
                w_hit        = 1'b1;
                w_hit_idx    = 3'(i);
                w_hit_base   = REGION_BASE[i*32 +: 32];
                w_hit_onehot = NUM_REGIONS'(1) << i;
            end
        end
    end

    assign w_hit_offset = req_addr - w_hit_base;

    // -------------------------------------------------------------------------
    // Transaction registers
    // -------------------------------------------------------------------------
    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_ready;
    logic [31:0]            r_offset;
    logic                   r_we;
    logic [DATA_W-1:0]      r_wdata;
    logic [2:0]             r_sel;
    logic [NUM_REGIONS-1:0] r_sel_onehot;
    logic [DATA_W-1:0]      r_resp_rdata;
    logic                   r_resp_err;
    logic [2:0]             r_resp_sel;

    logic                   w_accept;
    logic                   w_in_access;
    logic                   w_slv_ready;
    logic [DATA_W-1:0]      w_sel_rdata;
    logic [DATA_W-1:0]      w_resp_rdata_d;
    logic                   w_resp_err_d;
    logic [2:0]             w_resp_sel_d;
    logic                   w_timeout;

    assign w_accept    = req_valid && r_ready;
    assign w_in_access = (r_state == S_ACCESS);

    // Only the selected port's ready and read data matter; the others are
    // masked off by the one-hot select.
    assign w_slv_ready = |(slv_ready & r_sel_onehot);

    always_comb begin
        w_sel_rdata = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (r_sel_onehot[i]) begin
                w_sel_rdata = w_sel_rdata | slv_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Optional ACCESS timeout
    // -------------------------------------------------------------------------
`ifdef BUS_ROUTER_TIMEOUT_EN
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TCNT_W-1:0] r_tcnt;
    logic [TCNT_W-1:0] w_tcnt_inc;

    assign w_tcnt_inc = r_tcnt + TCNT_W'(1);
    // Fires on the ACCESS cycle that would bring the count to TIMEOUT_CYCLES,
    // so ACCESS lasts exactly TIMEOUT_CYCLES cycles when no ready arrives.
    assign w_timeout  = w_in_access && (w_tcnt_inc == TCNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tcnt <= '0;
        end else if (w_accept) begin
            r_tcnt <= '0;
        end else if (w_in_access && !w_slv_ready) begin
            r_tcnt <= w_tcnt_inc;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // FSM next state and response values
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next   = r_state;
        w_resp_rdata_d = '0;
        w_resp_err_d   = 1'b0;
        w_resp_sel_d   = 3'd0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_hit) begin
                        w_state_next = S_ACCESS;
                    end else begin
                        w_state_next = S_RESP;
                        w_resp_err_d = 1'b1;
                    end
                end
            end
            S_ACCESS: begin
                // A ready in the same cycle as the timeout still completes
                // the transfer normally.
                if (w_slv_ready) begin
                    w_state_next   = S_RESP;
                    w_resp_rdata_d = r_we ? '0 : w_sel_rdata;
                    w_resp_sel_d   = r_sel;
                end else if (w_timeout) begin
                    w_state_next = S_RESP;
                    w_resp_err_d = 1'b1;
                    w_resp_sel_d = r_sel;
                end
            end
            S_RESP: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_ready      <= 1'b0;
            r_offset     <= 32'h0;
            r_we         <= 1'b0;
            r_wdata      <= '0;
            r_sel        <= 3'd0;
            r_sel_onehot <= '0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            r_resp_sel   <= 3'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the values from before this edge.
            r_state <= w_state_next;
            // Registered so it stays low through the first edge after reset
            // and is high exactly while the FSM sits in IDLE.
            r_ready <= (w_state_next == S_IDLE);

            if (w_accept && w_hit) begin
                r_offset     <= w_hit_offset;
                r_we         <= req_we;
                r_wdata      <= req_wdata;
                r_sel        <= w_hit_idx;
                r_sel_onehot <= w_hit_onehot;
            end

            if (w_state_next == S_RESP) begin
                r_resp_rdata <= w_resp_rdata_d;
                r_resp_err   <= w_resp_err_d;
                r_resp_sel   <= w_resp_sel_d;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign req_ready  = r_ready;

    // The slave bus is forced to zero outside ACCESS so idle ports never see
    // stale addresses or data.
    assign slv_valid  = w_in_access ? r_sel_onehot : '0;
    assign slv_addr   = w_in_access ? r_offset     : 32'h0;
    assign slv_we     = w_in_access ? r_we         : 1'b0;
    assign slv_wdata  = w_in_access ? r_wdata      : '0;

    assign resp_valid = (r_state == S_RESP);
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;
    assign resp_sel   = r_resp_sel;

endmodule

// File: tb/tb_bus_router.sv
// -----------------------------------------------------------------------------
// tb_bus_router
//
// Directed testbench for bus_router. Inputs change on the falling clock edge
// and outputs are sampled there, half a cycle away from the active edge.
// A second, small instance covers overlapping regions and a region that ends
// exactly at 2^32.
// -----------------------------------------------------------------------------
module tb_bus_router;

    logic         clk = 1'b0;
    logic         rst;

    logic         req_valid;
    logic         req_ready;
    logic [31:0]  req_addr;
    logic         req_we;
    logic [31:0]  req_wdata;
    logic [3:0]   slv_valid;
    logic [3:0]   slv_ready;
    logic [31:0]  slv_addr;
    logic         slv_we;
    logic [31:0]  slv_wdata;
    logic [127:0] slv_rdata;
    logic         resp_valid;
    logic [31:0]  resp_rdata;
    logic         resp_err;
    logic [2:0]   resp_sel;

    logic         b_req_valid;
    logic         b_req_ready;
    logic [31:0]  b_req_addr;
    logic [1:0]   b_slv_valid;
    logic [31:0]  b_slv_addr;
    logic         b_slv_we;
    logic [31:0]  b_slv_wdata;
    logic         b_resp_valid;
    logic [31:0]  b_resp_rdata;
    logic         b_resp_err;
    logic [2:0]   b_resp_sel;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bus_router #(
        .NUM_REGIONS    (4),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (8)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_we     (req_we),
        .req_wdata  (req_wdata),
        .slv_valid  (slv_valid),
        .slv_ready  (slv_ready),
        .slv_addr   (slv_addr),
        .slv_we     (slv_we),
        .slv_wdata  (slv_wdata),
        .slv_rdata  (slv_rdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .resp_sel   (resp_sel)
    );

    // Region 0: 0xFFFF_0000..0xFFFF_FFFF (ends at 2^32)
    // Region 1: 0xFFFF_F000..0xFFFF_FFFF (fully inside region 0)
    bus_router #(
        .NUM_REGIONS    (2),
        .DATA_W         (32),
        .REGION_BASE    ({32'hFFFF_F000, 32'hFFFF_0000}),
        .REGION_SIZE    ({32'h0000_1000, 32'h0001_0000}),
        .TIMEOUT_CYCLES (8)
    ) u_wrap (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (b_req_valid),
        .req_ready  (b_req_ready),
        .req_addr   (b_req_addr),
        .req_we     (1'b0),
        .req_wdata  (32'h0),
        .slv_valid  (b_slv_valid),
        .slv_ready  (2'b11),
        .slv_addr   (b_slv_addr),
        .slv_we     (b_slv_we),
        .slv_wdata  (b_slv_wdata),
        .slv_rdata  ({32'h2222_2222, 32'h1111_1111}),
        .resp_valid (b_resp_valid),
        .resp_rdata (b_resp_rdata),
        .resp_err   (b_resp_err),
        .resp_sel   (b_resp_sel)
    );

    // Presents one request on the main DUT; returns at the falling edge of
    // the cycle after acceptance.
    task automatic issue(input logic [31:0] a, input logic we, input logic [31:0] wd);
        int waited;
        waited = 0;
        while (req_ready !== 1'b1 && waited < 16) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_ready got %0b expected 1", req_ready);
        end
        req_valid = 1'b1;
        req_addr  = a;
        req_we    = we;
        req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 32'h0;
        req_we    = 1'b0;
        req_wdata = 32'h0;
    endtask

    // Read through the main DUT and check the full hit or miss sequence.
    task automatic do_read(input string name, input logic [31:0] a, input bit hit,
                           input int sel, input logic [31:0] off, input logic [31:0] rd);
        logic [3:0]  ev;
        logic [31:0] hold;
        ev   = 4'b0001 << sel;
        hold = hit ? rd : 32'h0;
        issue(a, 1'b0, 32'h0);
        if (hit) begin
            checks++;
            if (slv_valid !== ev) begin
                errors++;
                $display("FAIL %s_slv_valid got %b expected %b", name, slv_valid, ev);
            end
            checks++;
            if (slv_addr !== off) begin
                errors++;
                $display("FAIL %s_slv_addr got %h expected %h", name, slv_addr, off);
            end
            checks++;
            if (resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s_early_resp got %b expected 0", name, resp_valid);
            end
            @(negedge clk);
            checks++;
            if (resp_valid !== 1'b1) begin
                errors++;
                $display("FAIL %s_resp_valid got %b expected 1", name, resp_valid);
            end
            checks++;
            if (resp_rdata !== rd) begin
                errors++;
                $display("FAIL %s_resp_rdata got %h expected %h", name, resp_rdata, rd);
            end
            checks++;
            if (resp_sel !== 3'(sel)) begin
                errors++;
                $display("FAIL %s_resp_sel got %0d expected %0d", name, resp_sel, sel);
            end
            checks++;
            if (resp_err !== 1'b0 || slv_valid !== 4'b0000 || slv_addr !== 32'h0) begin
                errors++;
                $display("FAIL %s_resp_phase err=%b slv_valid=%b slv_addr=%h expected 0/0000/0",
                         name, resp_err, slv_valid, slv_addr);
            end
        end else begin
            checks++;
            if (slv_valid !== 4'b0000) begin
                errors++;
                $display("FAIL %s_miss_slv_valid got %b expected 0000", name, slv_valid);
            end
            checks++;
            if (resp_valid !== 1'b1 || resp_err !== 1'b1) begin
                errors++;
                $display("FAIL %s_miss_resp valid=%b err=%b expected 1/1", name, resp_valid, resp_err);
            end
            checks++;
            if (resp_rdata !== 32'h0 || resp_sel !== 3'd0) begin
                errors++;
                $display("FAIL %s_miss_data rdata=%h sel=%0d expected 0/0", name, resp_rdata, resp_sel);
            end
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_after resp_valid=%b req_ready=%b expected 0/1", name, resp_valid, req_ready);
        end
        checks++;
        if (resp_rdata !== hold) begin
            errors++;
            $display("FAIL %s_hold got %h expected %h", name, resp_rdata, hold);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0 || slv_valid !== 4'b0000 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl ready=%b slv_valid=%b resp_valid=%b expected 0/0000/0",
                     req_ready, slv_valid, resp_valid);
        end
        checks++;
        if (resp_err !== 1'b0 || resp_rdata !== 32'h0 || resp_sel !== 3'd0 || slv_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_data err=%b rdata=%h sel=%0d addr=%h expected all 0",
                     resp_err, resp_rdata, resp_sel, slv_addr);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_before_edge got %b expected 0", req_ready);
        end
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_after_edge got %b expected 1", req_ready);
        end
    endtask

    task automatic test_read_hit();
        slv_ready = 4'b0010;
        do_read("read_hit", 32'h8000_2004, 1'b1, 1, 32'h4, 32'hDEAD_BEEF);
    endtask

    task automatic test_miss();
        slv_ready = 4'b1111;
        do_read("miss", 32'h2000_0000, 1'b0, 0, 32'h0, 32'h0);
    endtask

    task automatic test_boundaries();
        slv_ready = 4'b1111;
        do_read("b_8000_1fff", 32'h8000_1FFF, 1'b1, 0, 32'h1FFF, 32'h1111_1111);
        do_read("b_8000_2000", 32'h8000_2000, 1'b1, 1, 32'h0,    32'hDEAD_BEEF);
        do_read("b_8000_a000", 32'h8000_A000, 1'b0, 0, 32'h0,    32'h0);
        do_read("b_1000_000f", 32'h1000_000F, 1'b1, 2, 32'hF,    32'h3333_3333);
        do_read("b_1000_0010", 32'h1000_0010, 1'b0, 0, 32'h0,    32'h0);
        do_read("b_7fff_ffff", 32'h7FFF_FFFF, 1'b0, 0, 32'h0,    32'h0);
        do_read("b_1000_200f", 32'h1000_200F, 1'b1, 3, 32'hF,    32'h4444_4444);
    endtask

    // Port 3 answers after 5 wait cycles; ready on the other ports must be ignored.
    task automatic test_write_wait();
        slv_ready = 4'b0111;
        issue(32'h1000_2008, 1'b1, 32'hCAFE_F00D);
        for (int k = 1; k <= 6; k++) begin
            checks++;
            if (slv_valid !== 4'b1000 || slv_we !== 1'b1 || slv_addr !== 32'h8 ||
                slv_wdata !== 32'hCAFE_F00D || resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL write_hold_c%0d valid=%b we=%b addr=%h wdata=%h resp=%b expected 1000/1/8/cafef00d/0",
                         k, slv_valid, slv_we, slv_addr, slv_wdata, resp_valid);
            end
            if (k == 6) slv_ready = 4'b1111;
            @(negedge clk);
        end
        checks++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'h0 || resp_sel !== 3'd3) begin
            errors++;
            $display("FAIL write_resp valid=%b err=%b rdata=%h sel=%0d expected 1/0/0/3",
                     resp_valid, resp_err, resp_rdata, resp_sel);
        end
        checks++;
        if (slv_valid !== 4'b0000 || slv_we !== 1'b0 || slv_wdata !== 32'h0) begin
            errors++;
            $display("FAIL write_bus_idle valid=%b we=%b wdata=%h expected 0000/0/0",
                     slv_valid, slv_we, slv_wdata);
        end
        @(negedge clk);
    endtask

    // req_valid held high: accepts every third cycle, responses two cycles later.
    task automatic test_back_to_back();
        bit exp_acc;
        bit exp_resp;
        slv_ready = 4'b1111;
        while (req_ready !== 1'b1) @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 32'h8000_0010;
        for (int k = 0; k < 7; k++) begin
            exp_acc  = (k % 3 == 0);
            exp_resp = (k % 3 == 2);
            checks++;
            if ((req_valid && req_ready) !== exp_acc || resp_valid !== exp_resp) begin
                errors++;
                $display("FAIL b2b_c%0d accept=%b resp_valid=%b expected %b/%b",
                         k, req_valid && req_ready, resp_valid, exp_acc, exp_resp);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        req_addr  = 32'h0;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_read_b(input string name, input logic [31:0] a, input bit hit,
                             input int sel, input logic [31:0] off, input logic [31:0] rd);
        logic [1:0] ev;
        int waited;
        ev     = 2'b01 << sel;
        waited = 0;
        while (b_req_ready !== 1'b1 && waited < 16) begin
            @(negedge clk);
            waited++;
        end
        b_req_valid = 1'b1;
        b_req_addr  = a;
        @(negedge clk);
        b_req_valid = 1'b0;
        b_req_addr  = 32'h0;
        if (hit) begin
            checks++;
            if (b_slv_valid !== ev || b_slv_addr !== off) begin
                errors++;
                $display("FAIL %s_slv valid=%b addr=%h expected %b/%h", name, b_slv_valid, b_slv_addr, ev, off);
            end
            @(negedge clk);
            checks++;
            if (b_resp_valid !== 1'b1 || b_resp_err !== 1'b0 || b_resp_rdata !== rd || b_resp_sel !== 3'(sel)) begin
                errors++;
                $display("FAIL %s_resp valid=%b err=%b rdata=%h sel=%0d expected 1/0/%h/%0d",
                         name, b_resp_valid, b_resp_err, b_resp_rdata, b_resp_sel, rd, sel);
            end
        end else begin
            checks++;
            if (b_slv_valid !== 2'b00 || b_resp_valid !== 1'b1 || b_resp_err !== 1'b1) begin
                errors++;
                $display("FAIL %s_miss slv_valid=%b resp_valid=%b err=%b expected 00/1/1",
                         name, b_slv_valid, b_resp_valid, b_resp_err);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_wrap_overlap();
        do_read_b("wrap_top",   32'hFFFF_FFFF, 1'b1, 0, 32'h0000_FFFF, 32'h1111_1111);
        do_read_b("overlap",    32'hFFFF_F800, 1'b1, 0, 32'h0000_F800, 32'h1111_1111);
        do_read_b("wrap_below", 32'hFFFE_FFFF, 1'b0, 0, 32'h0,         32'h0);
    endtask

`ifdef BUS_ROUTER_TIMEOUT_EN
    task automatic test_timeout();
        slv_ready = 4'b0000;
        issue(32'h8000_0100, 1'b0, 32'h0);
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if ({resp_valid, slv_valid} !== 5'b0_0001) begin
                errors++;
                $display("FAIL timeout_wait_c%0d resp_valid=%b slv_valid=%b expected 0/0001", k, resp_valid, slv_valid);
            end
            @(negedge clk);
        end
        checks++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'h0 || slv_valid !== 4'b0000) begin
            errors++;
            $display("FAIL timeout_resp valid=%b err=%b rdata=%h slv_valid=%b expected 1/1/0/0000",
                     resp_valid, resp_err, resp_rdata, slv_valid);
        end
        @(negedge clk);
        // Ready arriving on the cycle the timeout would fire wins.
        issue(32'h8000_0100, 1'b0, 32'h0);
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if ({resp_valid, slv_valid} !== 5'b0_0001) begin
                errors++;
                $display("FAIL coincide_wait_c%0d resp_valid=%b slv_valid=%b expected 0/0001", k, resp_valid, slv_valid);
            end
            if (k == 8) slv_ready = 4'b0001;
            @(negedge clk);
        end
        checks++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'h1111_1111) begin
            errors++;
            $display("FAIL coincide_resp valid=%b err=%b rdata=%h expected 1/0/11111111",
                     resp_valid, resp_err, resp_rdata);
        end
        slv_ready = 4'b0000;
        @(negedge clk);
    endtask
`else
    task automatic test_no_timeout();
        slv_ready = 4'b0000;
        issue(32'h8000_0100, 1'b0, 32'h0);
        for (int k = 1; k <= 20; k++) begin
            checks++;
            if ({resp_valid, slv_valid} !== 5'b0_0001 || slv_addr !== 32'h100) begin
                errors++;
                $display("FAIL wait_c%0d resp_valid=%b slv_valid=%b addr=%h expected 0/0001/100",
                         k, resp_valid, slv_valid, slv_addr);
            end
            if (k == 20) slv_ready = 4'b0001;
            @(negedge clk);
        end
        checks++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'h1111_1111 || resp_sel !== 3'd0) begin
            errors++;
            $display("FAIL wait_resp valid=%b err=%b rdata=%h sel=%0d expected 1/0/11111111/0",
                     resp_valid, resp_err, resp_rdata, resp_sel);
        end
        slv_ready = 4'b0000;
        @(negedge clk);
    endtask
`endif

    task automatic test_reset_mid();
        slv_ready = 4'b0000;
        issue(32'h8000_2010, 1'b0, 32'h0);
        checks++;
        if (slv_valid !== 4'b0010) begin
            errors++;
            $display("FAIL midrst_access got %b expected 0010", slv_valid);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (slv_valid !== 4'b0000 || resp_valid !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async slv_valid=%b resp_valid=%b req_ready=%b expected 0000/0/0",
                     slv_valid, resp_valid, req_ready);
        end
        checks++;
        if (resp_rdata !== 32'h0 || resp_err !== 1'b0 || resp_sel !== 3'd0) begin
            errors++;
            $display("FAIL midrst_resp_regs rdata=%h err=%b sel=%0d expected 0/0/0", resp_rdata, resp_err, resp_sel);
        end
        slv_ready = 4'b1111;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_ready_before_edge got %b expected 0", req_ready);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (resp_valid !== 1'b0 || slv_valid !== 4'b0000 || req_ready !== 1'b1) begin
                errors++;
                $display("FAIL midrst_after_c%0d resp_valid=%b slv_valid=%b req_ready=%b expected 0/0000/1",
                         k, resp_valid, slv_valid, req_ready);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_addr    = 32'h0;
        req_we      = 1'b0;
        req_wdata   = 32'h0;
        slv_ready   = 4'b0000;
        slv_rdata   = {32'h4444_4444, 32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111};
        b_req_valid = 1'b0;
        b_req_addr  = 32'h0;

        test_reset();
        test_read_hit();
        test_miss();
        test_boundaries();
        test_write_wait();
        test_back_to_back();
        test_wrap_overlap();
`ifdef BUS_ROUTER_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_router.md
BUS_ROUTER -- requirements
Module: bus_router

Interface
- REQ-001: Parameter NUM_REGIONS, default 4, number of target regions/ports (1..8).
- REQ-002: Parameter DATA_W, default 32, data width; address width is fixed at 32.
- REQ-003: Parameter REGION_BASE, default {32'h1000_2000, 32'h1000_0000, 32'h8000_2000, 32'h8000_0000}, packed NUM_REGIONS x 32 region base addresses; entry 0 in the LSBs.
- REQ-004: Parameter REGION_SIZE, default {32'h10, 32'h10, 32'h8000, 32'h2000}, packed NUM_REGIONS x 32 region sizes in bytes; each size is nonzero.
- REQ-005: Parameter TIMEOUT_CYCLES, default 255, maximum wait in ACCESS before an error response.
- REQ-006: clk  in  1  sole clock; all logic is on the rising edge.
- REQ-007: rst  in  1  asynchronous, active-high reset.
- REQ-008: req_valid / req_ready  in / out  1 / 1  master request handshake.
- REQ-009: req_addr / req_we / req_wdata  in  32 / 1 / DATA_W  request address, write flag and write data.
- REQ-010: slv_valid / slv_ready  out / in  NUM_REGIONS / NUM_REGIONS  per-port strobes, one-hot or zero.
- REQ-011: slv_addr / slv_we / slv_wdata  out  32 / 1 / DATA_W  shared port bus; slv_addr is the region-relative offset.
- REQ-012: slv_rdata  in  NUM_REGIONS x DATA_W  packed per-port read data.
- REQ-013: resp_valid / resp_rdata / resp_err / resp_sel  out  1 / DATA_W / 1 / 3  response pulse, read data, error flag and region index.

Function
- REQ-014: Region i is hit when REGION_BASE[i] <= req_addr < REGION_BASE[i] + REGION_SIZE[i]; compute this in 33-bit arithmetic so that a region ending at 2^32 cannot wrap.
- REQ-015: Overlapping hits resolve to the lowest index.
- REQ-016: The FSM has three states: IDLE, ACCESS and RESP.
- REQ-017: req_ready is 1 only in IDLE; a request is accepted on req_valid && req_ready.
- REQ-018: On a hit, latch the offset (req_addr - base), req_we, req_wdata and the index, then go to ACCESS.
- REQ-019: On a miss, go to RESP with resp_err = 1, resp_rdata = 0 and resp_sel = 0; no slv_valid is asserted.
- REQ-020: In ACCESS, slv_valid[sel] is held high and the slv bus is held stable until slv_ready[sel] is 1.
- REQ-021: On the slv_ready[sel] cycle, capture slv_rdata[sel] (reads only; writes return 0) and go to RESP with err = 0.
- REQ-022: slv_ready on non-selected ports is ignored.
- REQ-023: RESP asserts resp_valid for exactly one cycle, then returns to IDLE; no response backpressure exists.
- REQ-024: resp_rdata, resp_err and resp_sel hold their values until the next RESP.
- REQ-025: Latency for a hit with slv_ready tied high: accept on cycle 0, slv_valid on cycle 1, resp_valid on cycle 2.
- REQ-026: Latency for a miss: resp_valid on cycle 1.
- REQ-027: Back-to-back requests are accepted every 3 cycles at best, with one transaction outstanding.
- REQ-028: slv_addr, slv_we and slv_wdata are 0 whenever slv_valid is all-zero.

Reset
- REQ-029: While rst is high: state = IDLE, req_ready = 0, slv_valid = 0, resp_valid = 0, resp_err = 0, resp_rdata = 0, resp_sel = 0, timeout counter = 0, and all latches are 0.
- REQ-030: Reset mid-transaction aborts without a response; req_ready rises on the first clk edge after rst deasserts.

Configuration
- REQ-031: Macro BUS_ROUTER_TIMEOUT_EN compiles the ACCESS timeout in or out.
- REQ-032: With BUS_ROUTER_TIMEOUT_EN defined, a counter cleared on ACCESS entry increments each ACCESS cycle without slv_ready.
- REQ-033: With the macro defined, when the counter reaches TIMEOUT_CYCLES the FSM drops slv_valid and goes to RESP with resp_err = 1 and resp_rdata = 0.
- REQ-034: If slv_ready and timeout coincide, slv_ready wins.
- REQ-035: With BUS_ROUTER_TIMEOUT_EN undefined, ACCESS waits indefinitely and no counter logic exists.

Verification
- REQ-036: Read 0x8000_2004 with port 1 ready and rdata 0xDEAD_BEEF -> slv_valid = 0b0010, slv_addr = 0x4, then resp_valid, resp_rdata = 0xDEAD_BEEF, resp_sel = 1, err = 0 two cycles after accept.
- REQ-037: Request to 0x2000_0000 (unmapped) -> no slv_valid, resp_valid one cycle after accept, resp_err = 1, resp_rdata = 0.
- REQ-038: Boundary addresses 0x8000_1FFF -> sel 0, 0x8000_2000 -> sel 1, 0x8000_A000 -> err, 0x1000_000F -> sel 2, 0x1000_0010 -> err.
- REQ-039: Write to 0x1000_2008 with port 3 ready delayed 5 cycles -> slv_valid[3], slv_we = 1 and slv_addr = 0x8 held stable for 6 cycles, resp_err = 0, resp_rdata = 0.
- REQ-040: With BUS_ROUTER_TIMEOUT_EN defined and TIMEOUT_CYCLES = 8, port 0 never ready -> slv_valid drops after 8 ACCESS cycles and the response has resp_err = 1.
- REQ-041: Assert rst during ACCESS -> slv_valid = 0 and resp_valid = 0 immediately (asynchronous); req_ready = 1 on the first edge after rst releases; no stale response appears.
